// File: rtl/exec_timer_exit_unit.sv
// exec_timer_exit_unit
//   Bus-slave peripheral that lets firmware time a kernel in system-clock
//   cycles and report a test exit code to the surrounding bench.
//
//   Ports:
//     clk_i, rst_i           system clock, synchronous active-high reset
//     req_i/gnt_o            bus request / combinational grant (always accepts)
//     we_i, be_i, addr_i     write enable, byte enables, byte address
//     wdata_i                write data
//     rvalid_o, rdata_o      response one cycle after every granted request
//     trig_o                 registered run trigger (RUNNING && TRIG_EN)
//     exit_valid_o           sticky exit flag, set by any EXIT write
//     exit_value_o           byte-merged exit return code
//
//   Register map (addr_i[4:2]):
//     0 CTRL      W: bit0 START, bit1 STOP, bit2 CLEAR; RW: bit3 TRIG_EN
//     1 STATUS    R: bit0 running, bit1 done, bit2 overflow
//     2 CYCLES_LO R: cnt[31:0], latches the upper count bits into hi_shadow
//     3 CYCLES_HI R: hi_shadow
//     4 RUN_COUNT R: completed intervals
//     5 EXIT      RW: exit code
//     6,7         read 0, writes ignored
module exec_timer_exit_unit #(
    parameter int unsigned CNT_WIDTH     = 64,
    parameter int unsigned RUN_CNT_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  trig_o,
    output logic                  exit_valid_o,
    output logic [31:0]           exit_value_o
);

    localparam int unsigned HI_WIDTH = CNT_WIDTH - 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic [CNT_WIDTH-1:0]     cnt_next;
    logic [RUN_CNT_WIDTH-1:0] run_cnt_q;
    logic [HI_WIDTH-1:0]      hi_shadow_q;
    logic                     overflow_q;
    logic                     trig_en_q;

    logic [2:0]  reg_sel;
    logic        wr_ctrl, wr_exit, rd_lo;
    logic        start_cmd, stop_cmd, clear_cmd;
    logic        is_running, count_en, cnt_max, run_done;
    logic [31:0] rd_val;
    logic [31:0] exit_merged;
    logic        unused_addr_bits;

    assign gnt_o = req_i;

    assign reg_sel = addr_i[4:2];
    assign unused_addr_bits = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};

    // CTRL commands only take effect through byte lane 0.
    assign wr_ctrl   = req_i && we_i && (reg_sel == 3'd0) && be_i[0];
    assign wr_exit   = req_i && we_i && (reg_sel == 3'd5);
    assign rd_lo     = req_i && !we_i && (reg_sel == 3'd2);
    assign start_cmd = wr_ctrl && wdata_i[0];
    assign stop_cmd  = wr_ctrl && wdata_i[1];
    assign clear_cmd = wr_ctrl && wdata_i[2];

    // The START-write cycle is spent outside RUNNING and the STOP-write
    // cycle is masked here, so neither of them is counted.
    assign is_running = (state_q == RUNNING);
    assign count_en   = is_running && !stop_cmd;
    assign cnt_max    = &cnt_q;
    assign run_done   = is_running && stop_cmd;

    // Next count kept as a single net so the flop loads it every cycle.
    assign cnt_next = clear_cmd             ? '0 :
                      (count_en && !cnt_max) ? cnt_q + CNT_WIDTH'(1) :
                                               cnt_q;

    // STOP wins over START when both arrive in the same write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_cmd && !stop_cmd) state_d = RUNNING;
            end
            RUNNING: begin
                if (stop_cmd) state_d = DONE;
            end
            DONE: begin
                if (start_cmd && !stop_cmd) state_d = RUNNING;
                else if (clear_cmd)         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            3'd0:    rd_val = {28'd0, trig_en_q, 3'd0};
            3'd1:    rd_val = {29'd0, overflow_q, (state_q == DONE), is_running};
            3'd2:    rd_val = cnt_q[31:0];
            3'd3:    rd_val = 32'(hi_shadow_q);
            3'd4:    rd_val = 32'(run_cnt_q);
            3'd5:    rd_val = exit_value_o;
            default: rd_val = 32'd0;
        endcase
    end

    always_comb begin
        exit_merged = exit_value_o;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) exit_merged[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    // A request granted in the reset cycle never gets a response because
    // rvalid_o is cleared by the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            run_cnt_q    <= '0;
            hi_shadow_q  <= '0;
            overflow_q   <= 1'b0;
            trig_en_q    <= 1'b0;
            trig_o       <= 1'b0;
            rvalid_o     <= 1'b0;
            rdata_o      <= 32'd0;
            exit_valid_o <= 1'b0;
            exit_value_o <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_next;

            if (clear_cmd)                overflow_q <= 1'b0;
            else if (count_en && cnt_max) overflow_q <= 1'b1;

            if (clear_cmd)     run_cnt_q <= '0;
            else if (run_done) run_cnt_q <= run_cnt_q + RUN_CNT_WIDTH'(1);

            if (clear_cmd)  hi_shadow_q <= '0;
            else if (rd_lo) hi_shadow_q <= cnt_q[CNT_WIDTH-1:32];

            if (wr_ctrl) trig_en_q <= wdata_i[3];
            trig_o <= is_running && trig_en_q;

            rvalid_o <= req_i;
            rdata_o  <= (req_i && !we_i) ? rd_val : 32'd0;

            if (wr_exit) begin
                exit_value_o <= exit_merged;
                exit_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_timer_exit_unit.sv
// tb_exec_timer_exit_unit
//   Self-checking bench for exec_timer_exit_unit: a vector table of bus
//   operations, directed sequences for timing, saturation and shadow
//   behaviour, and a random bus stream compared to a cycle-arithmetic model.
module tb_exec_timer_exit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, trig, ev;
    logic [31:0] rdata, ex;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    exec_timer_exit_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .gnt_o        (gnt),
        .we_i         (we),
        .be_i         (be),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .trig_o       (trig),
        .exit_valid_o (ev),
        .exit_value_o (ex)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [2:0]  r;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ev;
        logic [31:0] exp_ex;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic setVec(input int i, input logic w, input logic [2:0] r,
                          input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] erd, input logic eev,
                          input logic [31:0] eex);
        vecs[i].we     = w;
        vecs[i].r      = r;
        vecs[i].be     = b;
        vecs[i].wdata  = d;
        vecs[i].exp_rd = erd;
        vecs[i].exp_ev = eev;
        vecs[i].exp_ex = eex;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // One bus operation: request in one cycle, response checked in the next.
    task automatic applyStimulus(input logic w, input logic [2:0] r,
                                 input logic [3:0] b, input logic [31:0] d,
                                 output logic [31:0] rd);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = {27'd0, r, 2'b00};
        be    = b;
        wdata = d;
        #1;
        checkOutput("gnt", 64'(gnt), 64'h1);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
        checkOutput("rvalid", 64'(rvalid), 64'h1);
        rd = rdata;
        if (w) checkOutput("write_rdata", 64'(rdata), 64'h0);
    endtask

    task automatic readExpect(input string name, input logic [2:0] r,
                              input logic [31:0] exp);
        logic [31:0] rd;
        applyStimulus(1'b0, r, 4'hF, 32'd0, rd);
        checkOutput(name, 64'(rd), 64'(exp));
    endtask

    task automatic writeReg(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] rd;
        applyStimulus(1'b1, r, 4'hF, d, rd);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        we  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'h0);
        checkOutput({tag, "_rdata"},  64'(rdata),  64'h0);
        checkOutput({tag, "_trig"},   64'(trig),   64'h0);
        checkOutput({tag, "_ev"},     64'(ev),     64'h0);
        checkOutput({tag, "_ex"},     64'(ex),     64'h0);
    endtask

    // Random bus stream against a model that tracks the count as elapsed
    // cycles since the interval start rather than stepping a counter.
    task automatic randomTest(input int ncyc);
        logic              m_running, m_done, m_trig_en, m_ev;
        logic [31:0]       m_ex, m_hi;
        logic [15:0]       m_run_cnt;
        longint unsigned   m_acc, cnt_now;
        int                m_start, t;
        logic              e_rvalid, e_trig, e_ev;
        logic [31:0]       e_rdata, e_ex;
        logic              do_req, w;
        logic [2:0]        r;
        logic [3:0]        b;
        logic [31:0]       d;

        doReset();
        m_running = 0; m_done = 0; m_trig_en = 0; m_ev = 0;
        m_ex = 0; m_hi = 0; m_run_cnt = 0; m_acc = 0; m_start = 0;
        e_rvalid = 0; e_trig = 0; e_ev = 0; e_rdata = 0; e_ex = 0;

        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            t = cyc;
            checkOutput("rnd_rvalid", 64'(rvalid), 64'(e_rvalid));
            checkOutput("rnd_rdata",  64'(rdata),  64'(e_rdata));
            checkOutput("rnd_trig",   64'(trig),   64'(e_trig));
            checkOutput("rnd_ev",     64'(ev),     64'(e_ev));
            checkOutput("rnd_ex",     64'(ex),     64'(e_ex));

            do_req = ($urandom_range(0, 3) != 0);
            w      = 1'($urandom_range(0, 1));
            r      = 3'($urandom_range(0, 7));
            b      = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            d      = $urandom;
            if (r == 3'd0) begin
                d = {28'd0, 4'($urandom_range(0, 15))};
                if (d[2]) d[1] = 1'b0;
            end

            cnt_now  = m_running ? m_acc + longint'(t - m_start - 1) : m_acc;
            e_trig   = m_running && m_trig_en;
            e_rvalid = do_req;
            e_rdata  = 32'd0;

            if (do_req && !w) begin
                case (r)
                    3'd0: e_rdata = {28'd0, m_trig_en, 3'd0};
                    3'd1: e_rdata = {29'd0, 1'b0, m_done, m_running};
                    3'd2: begin
                        e_rdata = cnt_now[31:0];
                        m_hi    = cnt_now[63:32];
                    end
                    3'd3: e_rdata = m_hi;
                    3'd4: e_rdata = {16'd0, m_run_cnt};
                    3'd5: e_rdata = m_ex;
                    default: e_rdata = 32'd0;
                endcase
            end

            if (do_req && w && r == 3'd0 && b[0]) begin
                if (m_running) begin
                    if (d[1]) begin
                        m_acc     = cnt_now;
                        m_running = 0;
                        m_done    = 1;
                        m_run_cnt = m_run_cnt + 16'd1;
                    end else if (d[2]) begin
                        m_acc     = 0;
                        m_start   = t;
                        m_run_cnt = 0;
                        m_hi      = 0;
                    end
                end else begin
                    if (d[2]) begin
                        m_acc     = 0;
                        m_run_cnt = 0;
                        m_hi      = 0;
                        m_done    = 0;
                    end
                    if (d[0] && !d[1]) begin
                        m_running = 1;
                        m_done    = 0;
                        m_start   = t;
                    end
                end
                m_trig_en = d[3];
            end

            if (do_req && w && r == 3'd5) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) m_ex[8*k +: 8] = d[8*k +: 8];
                m_ev = 1;
            end
            e_ev = m_ev;
            e_ex = m_ex;

            req   = do_req;
            we    = w;
            addr  = {27'd0, r, 2'b00};
            be    = b;
            wdata = d;
        end
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;

        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0;

        setVec( 0, 0, 3'd1, 4'hF, 32'h0,        32'h0,        0, 32'h0);
        setVec( 1, 1, 3'd0, 4'hF, 32'h3,        32'h0,        0, 32'h0);
        setVec( 2, 0, 3'd1, 4'hF, 32'h0,        32'h0,        0, 32'h0);
        setVec( 3, 1, 3'd0, 4'hF, 32'h1,        32'h0,        0, 32'h0);
        setVec( 4, 0, 3'd1, 4'hF, 32'h0,        32'h1,        0, 32'h0);
        setVec( 5, 1, 3'd0, 4'hF, 32'h3,        32'h0,        0, 32'h0);
        setVec( 6, 0, 3'd1, 4'hF, 32'h0,        32'h2,        0, 32'h0);
        setVec( 7, 0, 3'd4, 4'hF, 32'h0,        32'h1,        0, 32'h0);
        setVec( 8, 1, 3'd0, 4'hF, 32'h4,        32'h0,        0, 32'h0);
        setVec( 9, 0, 3'd1, 4'hF, 32'h0,        32'h0,        0, 32'h0);
        setVec(10, 0, 3'd4, 4'hF, 32'h0,        32'h0,        0, 32'h0);
        setVec(11, 0, 3'd2, 4'hF, 32'h0,        32'h0,        0, 32'h0);
        setVec(12, 0, 3'd6, 4'hF, 32'h0,        32'h0,        0, 32'h0);
        setVec(13, 1, 3'd7, 4'hF, 32'hFFFFFFFF, 32'h0,        0, 32'h0);
        setVec(14, 1, 3'd0, 4'hE, 32'h1,        32'h0,        0, 32'h0);
        setVec(15, 0, 3'd1, 4'hF, 32'h0,        32'h0,        0, 32'h0);
        setVec(16, 1, 3'd5, 4'hF, 32'h2A,       32'h0,        1, 32'h2A);
        setVec(17, 0, 3'd5, 4'hF, 32'h0,        32'h2A,       1, 32'h2A);
        setVec(18, 1, 3'd5, 4'h1, 32'h0,        32'h0,        1, 32'h0);
        setVec(19, 1, 3'd5, 4'h0, 32'hFFFFFFFF, 32'h0,        1, 32'h0);
        setVec(20, 1, 3'd5, 4'h4, 32'h12AB3456, 32'h0,        1, 32'h00AB0000);
        setVec(21, 0, 3'd5, 4'hF, 32'h0,        32'h00AB0000, 1, 32'h00AB0000);
        setVec(22, 1, 3'd0, 4'hF, 32'h8,        32'h0,        1, 32'h00AB0000);
        setVec(23, 0, 3'd0, 4'hF, 32'h0,        32'h8,        1, 32'h00AB0000);
        setVec(24, 1, 3'd0, 4'hF, 32'h0,        32'h0,        1, 32'h00AB0000);

        doReset();
        checkAllZero("reset");

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].we, vecs[i].r, vecs[i].be, vecs[i].wdata, rd);
            if (!vecs[i].we)
                checkOutput($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            checkOutput($sformatf("vec%0d_ev", i), 64'(ev), 64'(vecs[i].exp_ev));
            checkOutput($sformatf("vec%0d_ex", i), 64'(ex), 64'(vecs[i].exp_ex));
        end

        doReset();
        checkOutput("exit_reset_ev", 64'(ev), 64'h0);
        checkOutput("exit_reset_ex", 64'(ex), 64'h0);

        // Timed interval with trigger window.
        writeReg(3'd0, 32'h9);
        checkOutput("trig_not_yet", 64'(trig), 64'h0);
        idle(1);
        checkOutput("trig_rise", 64'(trig), 64'h1);
        idle(99);
        checkOutput("trig_hold", 64'(trig), 64'h1);
        writeReg(3'd0, 32'h2);
        checkOutput("trig_stop_cycle", 64'(trig), 64'h1);
        idle(1);
        checkOutput("trig_fall", 64'(trig), 64'h0);
        readExpect("interval_lo",     3'd2, 32'd101);
        readExpect("interval_hi",     3'd3, 32'd0);
        readExpect("interval_runcnt", 3'd4, 32'd1);
        readExpect("interval_status", 3'd1, 32'h2);
        readExpect("interval_ctrl",   3'd0, 32'h0);

        // Restart from DONE accumulates.
        writeReg(3'd0, 32'h1);
        idle(9);
        writeReg(3'd0, 32'h2);
        readExpect("accum_lo",     3'd2, 32'd111);
        readExpect("accum_runcnt", 3'd4, 32'd2);
        writeReg(3'd0, 32'h4);
        readExpect("clear_status", 3'd1, 32'h0);
        readExpect("clear_lo",     3'd2, 32'h0);
        readExpect("clear_runcnt", 3'd4, 32'h0);

        // Saturation and sticky overflow.
        @(negedge clk);
        force dut.cnt_next = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        release dut.cnt_next;
        readExpect("sat_preload_lo", 3'd2, 32'hFFFFFFFE);
        writeReg(3'd0, 32'h1);
        idle(5);
        readExpect("sat_status", 3'd1, 32'h5);
        readExpect("sat_lo",     3'd2, 32'hFFFFFFFF);
        readExpect("sat_hi",     3'd3, 32'hFFFFFFFF);
        idle(3);
        readExpect("sat_lo_hold", 3'd2, 32'hFFFFFFFF);
        writeReg(3'd0, 32'h2);
        readExpect("sat_status_done", 3'd1, 32'h6);
        writeReg(3'd0, 32'h4);
        readExpect("sat_clear_status", 3'd1, 32'h0);
        readExpect("sat_clear_lo",     3'd2, 32'h0);
        readExpect("sat_clear_hi",     3'd3, 32'h0);

        // High-word shadow stays put until the next low read.
        writeReg(3'd0, 32'h1);
        @(negedge clk);
        force dut.cnt_next = 64'h1_FFFF_FFF0;
        @(negedge clk);
        release dut.cnt_next;
        readExpect("shadow_lo1", 3'd2, 32'hFFFFFFF1);
        idle(50);
        readExpect("shadow_hi1", 3'd3, 32'h1);
        readExpect("shadow_lo2", 3'd2, 32'h27);
        readExpect("shadow_hi2", 3'd3, 32'h2);
        writeReg(3'd0, 32'h2);
        writeReg(3'd0, 32'h4);

        randomTest(3000);

        // Request presented together with reset gets no response.
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h4;
        be   = 4'hF;
        rst  = 1'b1;
        @(negedge clk);
        checkOutput("rst_drop_rvalid", 64'(rvalid), 64'h0);
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("rst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
